alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Handshaked execute-stage ALU that consumes the 4-bit `alucontrol` code from the ALU control decoder together with two operands. It produces a registered result and a zero flag for writeback and branch resolution. Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, unless the barrel-shifter option is compiled in.

## Interface
- `XLEN`, 32: operand/result width; a power of two, at least 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived; do not override).
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: unit can accept an operation this cycle.
- `alucontrol` in 4: operation code.
- `a` in XLEN: operand A (rs1).
- `b` in XLEN: operand B (rs2 or immediate); shift amount is `b[SHW-1:0]`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `result` out XLEN: registered result.
- `zero` out 1: registered, `result == 0`.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 1001 SLL, 1010 SLT (signed), 1011 SLTU, 1100 SRL, 1101 SRA.
  - Any other code: result 0, zero 1; no error signalled.
- ADD/SUB wrap modulo 2^XLEN; carry is discarded.
- SLT/SLTU return 1 or 0, zero-extended to XLEN.
- States:
  - IDLE: no result held.
  - SHIFT: iterative shift in progress.
  - HOLD: `out_valid`=1, result waiting.
- `in_ready` = (state==IDLE) | (state==HOLD & out_ready).
- Accept occurs when `in_valid & in_ready`. On accept:
  - Non-shift op: compute, load `result`/`zero`, go to HOLD.
  - Shift with shamt 0: load `a`, go to HOLD.
  - Shift with shamt ≠ 0: load `a` into the work register and shamt into a down-counter, go to SHIFT.
- SHIFT, each cycle:
  - Shift the work register by 1 (SLL: insert 0 at LSB; SRL: insert 0 at MSB; SRA: replicate MSB).
  - Decrement the counter.
  - When the counter reaches 0, load `result`/`zero` and go to HOLD.
- HOLD:
  - `out_ready`=1 with no new accept: go to IDLE.
  - `out_ready`=1 with `in_valid`=1: accept back-to-back in the same cycle and follow the accept rules above.
  - `out_ready`=0: hold `result`/`zero` stable.
- `a`, `b` and `alucontrol` are sampled only on accept; later changes have no effect on an op in flight.
- `rst` mid-shift abandons the op; no result is produced.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `zero` 0, `in_ready` 1 (combinational from state), counter 0.
- Non-shift op or shamt 0: accept at cycle N, `out_valid`=1 at N+1.
- Iterative shift by k (1..XLEN-1): accept at N, `out_valid` at N+k.
- `in_ready`=0 throughout SHIFT.
- Throughput with `out_ready` held at 1: one non-shift op per cycle.
- `out_valid` and `result` are pure register outputs; `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - Shifts are computed combinationally on accept, like non-shift ops; latency is 1 cycle for every op.
  - The SHIFT state and the counter are not synthesised.
- `ALU_BARREL_SHIFT_EN` undefined: iterative shifter as described, latency k cycles for shamt k (minimum 1).

## Test plan
- Reset: assert `rst` 2 cycles, then check `out_valid`=0, `result`=0, `zero`=0, `in_ready`=1.
- ADD 0xFFFFFFFF+1 (code 0010) with `out_ready`=1: next cycle `result`=0, `zero`=1, `out_valid`=1.
- SUB 5−7 → 0xFFFFFFFE, then SLT 0xFFFFFFFE<1 → 1 and SLTU → 0.
  - Issue back-to-back; expect one result per cycle in order.
- SRA a=0x80000000, b=4:
  - Iterative build: `in_ready`=0 for cycles N+1..N+3; `out_valid` at N+4 with 0xF8000000.
  - Barrel build: result at N+1.
- Backpressure: hold `out_ready`=0 for 5 cycles after XOR 0xF0F0F0F0^0xFFFF0000.
  - `result` stays 0x0F0FF0F0; `in_ready` stays 0.
  - On release, accept the next op in the same cycle.
- Reset mid-shift: SLL b=20, assert `rst` at N+3. Expect no `out_valid`, state IDLE, and the next ADD 2+3 returns 5 at latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU with registered result and zero flag.
// Logic, arithmetic and compare ops complete in one cycle. Shifts run one bit
// per cycle unless the ALU_BARREL_SHIFT_EN macro is defined, in which case
// every op, shifts included, completes in one cycle.
module alu_exec_unit #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic [SHW-1:0]  w_shamt;
  logic            w_accept;
  logic [XLEN-1:0] w_res;
  logic            w_start_shift;
  logic            w_shift_done;
  logic [XLEN-1:0] w_shift_res;

  // Single-bit shift step used by the iterative shifter.
  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [3:0] op);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = {1'b0, v[XLEN-1:1]};
    endcase
    return r;
  endfunction

  assign w_shamt   = b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

  // Single-cycle result for the op presented on the inputs.
  always_comb begin
    w_res = '0;
    case (alucontrol)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD:  w_res = a + b;
      OP_XOR:  w_res = a ^ b;
      OP_SUB:  w_res = a - b;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  w_res = a << w_shamt;
      OP_SRL:  w_res = a >> w_shamt;
      OP_SRA:  w_res = XLEN'($signed(a) >>> w_shamt);
`else
      // Shift by 0 or 1 finishes on accept; longer shifts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA:
        w_res = (w_shamt == '0) ? a : shift1(a, alucontrol);
`endif
      default: w_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign w_start_shift = 1'b0;
  assign w_shift_done  = 1'b0;
  assign w_shift_res   = '0;
`else
  logic [XLEN-1:0] r_work;
  logic [SHW-1:0]  r_cnt;
  logic [3:0]      r_shop;

  // The first bit is shifted on accept so a shift by k reports after k cycles.
  assign w_start_shift = ((alucontrol == OP_SLL) || (alucontrol == OP_SRL) ||
                          (alucontrol == OP_SRA)) && (w_shamt > SHW'(1));
  assign w_shift_res   = shift1(r_work, r_shop);
  assign w_shift_done  = (r_state == ST_SHIFT) && (r_cnt == SHW'(1));

  // Iterative shifter datapath: work register plus remaining-bits counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_shop <= '0;
    end else if (w_accept && w_start_shift) begin
      r_work <= shift1(a, alucontrol);
      r_cnt  <= w_shamt - SHW'(1);
      r_shop <= alucontrol;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_shift_res;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end
`endif

  // Control FSM with registered result, zero flag and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_SHIFT;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end else if ((r_state == ST_HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_shift_done) begin
            r_result    <= w_shift_res;
            r_zero      <= (w_shift_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard testbench for alu_exec_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_rdy = 0;
  bit head_seen = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          due;
    logic [3:0]  code;
  } exp_t;
  exp_t q[$];

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input int acc);
    exp_t e;
    int sh;
    sh = int'(y[4:0]);
    case (c)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: e.res = x + y;
      4'b0011: e.res = x ^ y;
      4'b0110: e.res = x - y;
      4'b1001: e.res = x << sh;
      4'b1010: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1011: e.res = (x < y) ? 32'd1 : 32'd0;
      4'b1100: e.res = x >> sh;
      4'b1101: e.res = $signed(x) >>> sh;
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    e.code = c;
    e.due = acc + 1;
`ifndef ALU_BARREL_SHIFT_EN
    if ((c == 4'b1001 || c == 4'b1100 || c == 4'b1101) && sh > 1) e.due = acc + sh;
`endif
    return e;
  endfunction

  // Present one op, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, output int waited);
    int n;
    alucontrol = c; a = x; b = y; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      q.push_back(model(c, x, y, cyc));
      $display("[TB] issue code=%b a=%h b=%h cycle=%0d", c, x, y, cyc);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alucontrol = 4'($urandom); a = $urandom; b = $urandom;
    end
  endtask

  // Monitor: compare the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!head_seen) begin
          chk("latency_cycle", cyc, q[0].due);
          head_seen = 1;
        end
        chk("result", result, q[0].res);
        chk("zero", {31'd0, zero}, {31'd0, q[0].z});
        if (out_ready) begin
          $display("[TB] result code=%b got=%h exp=%h zero=%b cycle=%0d",
                   q[0].code, result, q[0].res, zero, cyc);
          void'(q.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  // Random backpressure generator, enabled during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic [3:0] codes [12];
  initial begin
    int w;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1001,
              4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0111, 4'b1111};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alucontrol = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Wrapping add, then back-to-back SUB/SLT/SLTU.
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, w);
    issue(4'b0110, 32'd5, 32'd7, w);
    issue(4'b1010, 32'hFFFF_FFFE, 32'd1, w);
    chk("b2b_no_stall", w, 0);
    issue(4'b1011, 32'hFFFF_FFFE, 32'd1, w);
    chk("b2b_no_stall", w, 0);
    repeat (3) @(posedge clk);
    #1;

    // SRA by 4: busy for three cycles in the iterative build.
    issue(4'b1101, 32'h8000_0000, 32'd4, w);
`ifndef ALU_BARREL_SHIFT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("shift_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
`endif
    repeat (6) @(posedge clk);
    #1;

    // Backpressure after XOR; release and accept in the same cycle.
    out_ready = 1'b0;
    issue(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", result, 32'h0F0F_F0F0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(4'b0001, 32'h1234_0000, 32'h0000_5678, w);
    chk("release_accept_same_cycle", w, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a long SLL abandons it.
    issue(4'b1001, 32'h0000_0001, 32'd20, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    head_seen = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    issue(4'b0010, 32'd2, 32'd3, w);
    repeat (3) @(posedge clk);
    #1;

    // Randomized ops with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = y & 32'h0000_0003;
      if ($urandom_range(0, 5) == 0) x = y;
      issue(codes[$urandom_range(0, 11)], x, y, w);
    end
    rand_rdy = 0;
    #2;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
